// File: rtl/icache_axi_refill_if.sv
// AXI4 read-address / read-data channel bundle between the icache refill
// engine (master) and the memory interconnect (slave).
interface icache_axi_refill_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/icache_axi_refill.sv
// Icache line refill engine: one 16x32-bit AXI4 INCR burst per miss, line returned with a reload pulse.
// Optional rresp checking is enabled by defining ICACHE_REFILL_RESP_CHECK_EN.
module icache_axi_refill #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 rd_req,
    input  logic [31:0]          rd_addr,
    output logic                 reload,
    output logic [511:0]         cacheline_new,
    output logic                 refill_err,
    icache_axi_refill_if.master  axi
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [15:0][31:0]  line_q, line_d;

    assign axi.arid    = AXI_ID;
    assign axi.arlen   = 8'd15;
    assign axi.arsize  = 3'b010;
    assign axi.arburst = 2'b01;
    assign axi.araddr  = addr_q;
    assign cacheline_new = line_q;

`ifdef ICACHE_REFILL_RESP_CHECK_EN
    logic err_q, err_d;
    logic unused_rid;
    assign unused_rid = ^axi.rid;
`else
    logic unused_rresp_rid;
    assign unused_rresp_rid = ^{axi.rid, axi.rresp};
`endif

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        line_d      = line_q;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        reload      = 1'b0;
        refill_err  = 1'b0;
`ifdef ICACHE_REFILL_RESP_CHECK_EN
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rd_req) begin
                    addr_d  = rd_addr & 32'hFFFF_FFC0;
                    cnt_d   = 4'd0;
`ifdef ICACHE_REFILL_RESP_CHECK_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_AR;
                end
            end
            S_AR: begin
                axi.arvalid = 1'b1;
                if (axi.arready) state_d = S_R;
            end
            S_R: begin
                // rready depends on state only, never on rvalid.
                axi.rready = 1'b1;
                if (axi.rvalid) begin
                    line_d[cnt_q] = axi.rdata;
                    cnt_d         = cnt_q + 4'd1;
`ifdef ICACHE_REFILL_RESP_CHECK_EN
                    if (axi.rresp != 2'b00) err_d = 1'b1;
`endif
                    if (axi.rlast) state_d = S_DONE;
                end
            end
            S_DONE: begin
`ifdef ICACHE_REFILL_RESP_CHECK_EN
                reload     = ~err_q;
                refill_err = err_q;
`else
                reload     = 1'b1;
`endif
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
            cnt_q   <= 4'd0;
`ifdef ICACHE_REFILL_RESP_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
`ifdef ICACHE_REFILL_RESP_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // NOTE: the line register is reset because the cache may observe cacheline_new straight out of reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) line_q <= '0;
        else         line_q <= line_d;
    end

endmodule

// File: tb/tb_icache_axi_refill.sv
// Self-checking bench for icache_axi_refill: table of refill scenarios driven by an AXI slave model,
// expected lines scoreboarded on the last beat and compared on reload / refill_err.
module tb_icache_axi_refill;

    localparam logic [3:0] TB_ID = 4'hA;
`ifdef ICACHE_REFILL_RESP_CHECK_EN
    localparam bit RESP_CHECK = 1'b1;
`else
    localparam bit RESP_CHECK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         resetn;
    logic         rd_req;
    logic [31:0]  rd_addr;
    logic         reload;
    logic [511:0] cacheline_new;
    logic         refill_err;

    icache_axi_refill_if axi ();

    icache_axi_refill #(.AXI_ID(TB_ID)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .reload        (reload),
        .cacheline_new (cacheline_new),
        .refill_err    (refill_err),
        .axi           (axi.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ar_wait;
        int          gap_a;
        int          gap_b;
        int          nbeats;
        logic [31:0] base;
        int          err_beat;
        bit          disturb;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [511:0] line;
        int           lat;
        bit           is_err;
    } exp_t;

    vec_t              vecs[8];
    exp_t              sb[$];
    logic [15:0][31:0] exp_line;
    int                total = 0;
    int                bad   = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_refill(input vec_t v);
        int          cyc, beat, ar_left, phase;
        bit          gap_a_done, gap_b_done, ar_ok, r_ok, done;
        logic [31:0] exp_addr;
        exp_t        e;
        exp_addr   = v.addr & 32'hFFFF_FFC0;
        cyc        = 0;
        beat       = 0;
        ar_left    = v.ar_wait;
        phase      = 0;
        gap_a_done = 0;
        gap_b_done = 0;
        ar_ok      = 1;
        r_ok       = 1;
        done       = 0;
        e.is_err   = 0;
        rd_req     = 1'b1;
        rd_addr    = v.addr;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            case (phase)
                0: begin
                    if (cyc == 1) check("line_hold", cacheline_new, exp_line);
                    if (axi.arvalid !== 1'b1 || axi.araddr !== exp_addr || axi.rready !== 1'b0)
                        ar_ok = 0;
                    if (ar_left > 0) begin
                        axi.arready = 1'b0;
                        ar_left--;
                    end else begin
                        axi.arready = 1'b1;
                        phase = 1;
                    end
                end
                1: begin
                    axi.arready = 1'b0;
                    if (axi.rready !== 1'b1 || axi.arvalid !== 1'b0 || axi.araddr !== exp_addr ||
                        reload !== 1'b0 || refill_err !== 1'b0)
                        r_ok = 0;
                    if (v.disturb) begin
                        rd_req  = ~rd_req;
                        rd_addr = $urandom;
                    end
                    if (beat == v.gap_a && !gap_a_done) begin
                        gap_a_done = 1;
                        axi.rvalid = 1'b0;
                        axi.rlast  = 1'b0;
                    end else if (beat == v.gap_b && !gap_b_done) begin
                        gap_b_done = 1;
                        axi.rvalid = 1'b0;
                        axi.rlast  = 1'b0;
                    end else begin
                        axi.rvalid = 1'b1;
                        axi.rdata  = v.base + beat;
                        axi.rlast  = (beat == v.nbeats - 1);
                        axi.rresp  = (beat == v.err_beat) ? 2'b10 : 2'b00;
                        exp_line[beat % 16] = v.base + beat;
                        beat++;
                        if (beat == v.nbeats) begin
                            e.line   = exp_line;
                            e.lat    = v.exp_lat;
                            e.is_err = RESP_CHECK && (v.err_beat >= 0);
                            sb.push_back(e);
                            phase = 2;
                        end
                    end
                end
                default: begin
                    axi.rvalid = 1'b0;
                    axi.rlast  = 1'b0;
                    axi.rresp  = 2'b00;
                    if (reload === 1'b1 || refill_err === 1'b1) begin
                        done = 1;
                        if (sb.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL sb_pop: completion seen with empty scoreboard");
                        end else begin
                            e = sb.pop_front();
                            check("latency", cyc, e.lat);
                            check("line", cacheline_new, e.line);
                            check("reload", reload, !e.is_err);
                            check("refill_err", refill_err, e.is_err);
                        end
                    end
                end
            endcase
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout: no completion for addr %0h within 100 cycles", v.addr);
        end
        check("ar_phase", ar_ok, 1'b1);
        check("r_phase", r_ok, 1'b1);
        @(posedge clk);
        #1;
        check("pulse_one_cycle", {reload, refill_err}, 2'b00);
        check("back_to_idle", {axi.arvalid, axi.rready}, 2'b00);
        // An errored refill leaves the miss pending so the next run is the retry.
        if (!e.is_err) rd_req = 1'b0;
    endtask

    task automatic reset_mid_refill();
        rd_req  = 1'b1;
        rd_addr = 32'h1111_1100;
        @(posedge clk);
        #1;
        axi.arready = 1'b1;
        @(posedge clk);
        #1;
        axi.arready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            axi.rvalid = 1'b1;
            axi.rdata  = 32'hDEAD_0000 + k;
            axi.rlast  = 1'b0;
            if (k < 7) begin
                @(posedge clk);
                #1;
            end
        end
        #2;
        resetn = 1'b0;
        #1;
        check("rst_mid_reload", reload, 1'b0);
        check("rst_mid_arvalid", axi.arvalid, 1'b0);
        check("rst_mid_rready", axi.rready, 1'b0);
        check("rst_mid_refill_err", refill_err, 1'b0);
        check("rst_mid_araddr", axi.araddr, 32'h0);
        check("rst_mid_line", cacheline_new, 512'h0);
        axi.rvalid = 1'b0;
        rd_req     = 1'b0;
        exp_line   = '0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release_idle", {axi.arvalid, reload}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //          addr          arw gapA gapB nb  base          err dist lat
        vecs[0] = '{32'hBFC0_0024, 0, -1, -1, 16, 32'h0000_1000, -1, 0, 18};
        vecs[1] = '{32'h0000_1234, 3,  4,  9, 16, 32'h0000_2000, -1, 0, 23};
        vecs[2] = '{32'hFFFF_FFFF, 0, -1, -1, 16, 32'hA5A5_0000, -1, 1, 18};
        vecs[3] = '{32'h8000_0040, 1, -1, -1, 10, 32'h0000_3000, -1, 0, 13};
        vecs[4] = '{32'h1234_5678, 0, -1, -1, 20, 32'h0000_4000, -1, 0, 22};
        vecs[5] = '{32'hCAFE_0080, 0, -1, -1, 16, 32'h0000_5000,  3, 0, 18};
        vecs[6] = '{32'hCAFE_0080, 0, -1, -1, 16, 32'h0000_6000, -1, 0, 18};
        vecs[7] = '{32'h0000_0040, 0, -1, -1, 16, 32'h0000_7000, -1, 0, 18};

        exp_line    = '0;
        resetn      = 1'b0;
        rd_req      = 1'b0;
        rd_addr     = 32'h0;
        axi.arready = 1'b0;
        axi.rid     = 4'h3;
        axi.rdata   = 32'h0;
        axi.rresp   = 2'b00;
        axi.rlast   = 1'b0;
        axi.rvalid  = 1'b0;

        #12;
        check("rst_reload", reload, 1'b0);
        check("rst_arvalid", axi.arvalid, 1'b0);
        check("rst_rready", axi.rready, 1'b0);
        check("rst_refill_err", refill_err, 1'b0);
        check("rst_araddr", axi.araddr, 32'h0);
        check("rst_line", cacheline_new, 512'h0);
        check("arid", axi.arid, TB_ID);
        check("arlen", axi.arlen, 8'd15);
        check("arsize", axi.arsize, 3'b010);
        check("arburst", axi.arburst, 2'b01);

        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) run_refill(vecs[i]);
        reset_mid_refill();
        run_refill(vecs[7]);

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
